// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with a configurable s=r=1 resolution
// (MODE) and an illegal-event flag; the counter exists only when SR_ILLEGAL_CNT_EN is defined.
module sr_ff_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [WIDTH-1:0] both_c;
  logic [WIDTH-1:0] tie_c;
  logic [WIDTH-1:0] q_nxt_c;
  logic             ill_evt_c;

  // Next state per channel; tie_c is the value taken when s=r=1
  always_comb begin
    both_c = s & r;
    case (MODE)
      0:       tie_c = '1;
      1:       tie_c = '0;
      2:       tie_c = ~q;
      default: tie_c = q;
    endcase
    q_nxt_c   = (q & ~(s | r)) | (s & ~r) | (both_c & tie_c);
    ill_evt_c = en & (|both_c);
  end

  // q_bar has its own flop loaded with the complement so it never lags or matches q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_bar   <= '1;
      illegal <= 1'b0;
    end else begin
      illegal <= ill_evt_c;
      if (en) begin
        q     <= q_nxt_c;
        q_bar <= ~q_nxt_c;
      end
    end
  end

`ifdef SR_ILLEGAL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counter; a same-edge clear overrides the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (clr_cnt) begin
      illegal_cnt <= '0;
    end else if (ill_evt_c && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign illegal_cnt    = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: one sr_ff_bank per MODE (WIDTH=4, CNT_W=2) driven in parallel
// and compared against a rule-level reference model.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic       clr_cnt = 1'b0;

  logic [3:0] q_w   [4];
  logic [3:0] qb_w  [4];
  logic       ill_w [4];
  logic [1:0] cnt_w [4];

  logic [3:0] mq [4];
  logic       mill;
  int         mcnt;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_ff_bank #(.WIDTH(4), .MODE(g), .CNT_W(2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
      .q(q_w[g]), .q_bar(qb_w[g]), .illegal(ill_w[g]), .illegal_cnt(cnt_w[g])
    );
  end

  task automatic model_reset();
    for (int m = 0; m < 4; m++) mq[m] = 4'h0;
    mill = 1'b0;
    mcnt = 0;
  endtask

  // Apply the SR truth table and the counter rules for one clock edge
  task automatic model_edge();
    logic any_both;
    any_both = 1'b0;
    for (int i = 0; i < 4; i++) if (s[i] && r[i]) any_both = 1'b1;
    if (en) begin
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i] && !r[i])      mq[m][i] = 1'b1;
          else if (!s[i] && r[i]) mq[m][i] = 1'b0;
          else if (s[i] && r[i]) begin
            if (m == 0)      mq[m][i] = 1'b1;
            else if (m == 1) mq[m][i] = 1'b0;
            else if (m == 2) mq[m][i] = !mq[m][i];
          end
        end
      end
    end
    mill = en && any_both;
`ifdef SR_ILLEGAL_CNT_EN
    if (clr_cnt) mcnt = 0;
    else if (mill && mcnt < 3) mcnt = mcnt + 1;
`else
    mcnt = 0;
`endif
  endtask

  task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
    en = e; s = sv; r = rv; clr_cnt = c;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    drive(1'b1, 4'hF, 4'h0, 1'b0);
    model_reset();
    #1;
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (q_w[m] !== 4'h0) begin n_err++; $display("FAIL reset_q m%0d got %h exp 0", m, q_w[m]); end
      n_cmp++; if (qb_w[m] !== 4'hF) begin n_err++; $display("FAIL reset_qbar m%0d got %h exp f", m, qb_w[m]); end
      n_cmp++; if (ill_w[m] !== 1'b0) begin n_err++; $display("FAIL reset_ill m%0d got %b exp 0", m, ill_w[m]); end
      n_cmp++; if (cnt_w[m] !== 2'd0) begin n_err++; $display("FAIL reset_cnt m%0d got %0d exp 0", m, cnt_w[m]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 4'b0101, 4'b1010, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      for (int m = 0; m < 4; m++) begin
        n_cmp++; if (q_w[m] !== 4'b0101 || q_w[m] !== mq[m]) begin n_err++; $display("FAIL basic_q k%0d m%0d got %b exp 0101", k, m, q_w[m]); end
        n_cmp++; if (qb_w[m] !== ~q_w[m]) begin n_err++; $display("FAIL basic_qbar m%0d got %b exp %b", m, qb_w[m], ~q_w[m]); end
      end
      drive(1'b1, 4'h0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_modes();
    logic [3:0] exp_q [4];
    exp_q[0] = 4'hF; exp_q[1] = 4'h0; exp_q[2] = 4'b1100; exp_q[3] = 4'b0011;
    drive(1'b1, 4'b0011, 4'b1100, 1'b0);
    step();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    step();
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (q_w[m] !== exp_q[m] || q_w[m] !== mq[m]) begin n_err++; $display("FAIL mode_q m%0d got %b exp %b", m, q_w[m], exp_q[m]); end
      n_cmp++; if (qb_w[m] !== ~exp_q[m]) begin n_err++; $display("FAIL mode_qbar m%0d got %b exp %b", m, qb_w[m], ~exp_q[m]); end
      n_cmp++; if (ill_w[m] !== 1'b1) begin n_err++; $display("FAIL mode_ill m%0d got %b exp 1", m, ill_w[m]); end
      n_cmp++; if (cnt_w[m] !== 2'(mcnt)) begin n_err++; $display("FAIL mode_cnt m%0d got %0d exp %0d", m, cnt_w[m], mcnt); end
    end
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    step();
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (ill_w[m] !== 1'b0) begin n_err++; $display("FAIL mode_ill_drop m%0d got %b exp 0", m, ill_w[m]); end
    end
  endtask

  task automatic test_enable();
    logic [3:0] held [4];
    for (int m = 0; m < 4; m++) held[m] = mq[m];
    for (int k = 0; k < 10; k++) begin
      if (k < 5) drive(1'b0, 4'hF, 4'h0, 1'b0);
      else       drive(1'b0, 4'hF, 4'hF, 1'b0);
      step();
      for (int m = 0; m < 4; m++) begin
        n_cmp++; if (q_w[m] !== held[m]) begin n_err++; $display("FAIL en_hold k%0d m%0d got %b exp %b", k, m, q_w[m], held[m]); end
        n_cmp++; if (ill_w[m] !== 1'b0) begin n_err++; $display("FAIL en_ill k%0d m%0d got %b exp 0", k, m, ill_w[m]); end
        n_cmp++; if (cnt_w[m] !== 2'(mcnt)) begin n_err++; $display("FAIL en_cnt k%0d m%0d got %0d exp %0d", k, m, cnt_w[m], mcnt); end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_seq [5];
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 3; exp_seq[4] = 3;
    drive(1'b0, 4'h0, 4'h0, 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 4'b0110, 4'b0110, (k == 5) ? 1'b1 : 1'b0);
      step();
      for (int m = 0; m < 4; m++) begin
`ifdef SR_ILLEGAL_CNT_EN
        n_cmp++; if (cnt_w[m] !== 2'((k < 5) ? exp_seq[k] : 0)) begin n_err++; $display("FAIL sat_cnt k%0d m%0d got %0d exp %0d", k, m, cnt_w[m], (k < 5) ? exp_seq[k] : 0); end
`else
        n_cmp++; if (cnt_w[m] !== 2'd0) begin n_err++; $display("FAIL sat_cnt_off k%0d m%0d got %0d exp 0", k, m, cnt_w[m]); end
`endif
        n_cmp++; if (ill_w[m] !== 1'b1) begin n_err++; $display("FAIL sat_ill k%0d m%0d got %b exp 1", k, m, ill_w[m]); end
        n_cmp++; if (q_w[m] !== mq[m]) begin n_err++; $display("FAIL sat_q k%0d m%0d got %b exp %b", k, m, q_w[m], mq[m]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 4'b1010, 4'b0101, 1'b0);
    step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (q_w[m] !== 4'h0) begin n_err++; $display("FAIL midrst_q m%0d got %h exp 0", m, q_w[m]); end
      n_cmp++; if (qb_w[m] !== 4'hF) begin n_err++; $display("FAIL midrst_qbar m%0d got %h exp f", m, qb_w[m]); end
      n_cmp++; if (ill_w[m] !== 1'b0 || cnt_w[m] !== 2'd0) begin n_err++; $display("FAIL midrst_ill m%0d got %b/%0d exp 0/0", m, ill_w[m], cnt_w[m]); end
    end
    #1 rst = 1'b0;
    drive(1'b1, 4'b1001, 4'b1000, 1'b0);
    step();
    for (int m = 0; m < 4; m++) begin
      n_cmp++; if (q_w[m] !== mq[m] || ill_w[m] !== mill) begin n_err++; $display("FAIL post_rst m%0d got %b/%b exp %b/%b", m, q_w[m], ill_w[m], mq[m], mill); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
      step();
      for (int m = 0; m < 4; m++) begin
        n_cmp++; if (q_w[m] !== mq[m] || qb_w[m] !== ~mq[m]) begin n_err++; $display("FAIL rnd_q k%0d m%0d got %b/%b exp %b", k, m, q_w[m], qb_w[m], mq[m]); end
        n_cmp++; if (ill_w[m] !== mill || cnt_w[m] !== 2'(mcnt)) begin n_err++; $display("FAIL rnd_ill k%0d m%0d got %b/%0d exp %b/%0d", k, m, ill_w[m], cnt_w[m], mill, mcnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_enable();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
